// File: rtl/bus_driver_arbiter.sv
// bus_driver_arbiter: round-robin owner of four tri-state bus drivers with turnaround gap and hold limit
module bus_driver_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] oen,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] last_q, last_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] pick, idx;
    logic [7:0] hold_q, hold_d;
    logic [3:0] turn_q, turn_d;
    logic       timeout_q, timeout_d;
    logic       own_req, hold_full, rel_drop, rel_to;
    assign own_req   = req[owner_q];
    assign hold_full = (MAX_HOLD != 0) && (hold_q == 8'(MAX_HOLD));
    assign rel_drop  = (state_q == OWN) && !own_req;
    assign rel_to    = (state_q == OWN) && own_req && hold_full;
    // rotating priority search from last+1; nearer hits overwrite farther ones, last itself ranks lowest
    always_comb begin
        pick = last_q;
        idx  = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (req[idx]) pick = idx;
        end
    end
    // state register and registered outputs; reset drops the driver enables without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            last_q    <= 2'd3;
            owner_q   <= 2'd0;
            hold_q    <= 8'd0;
            turn_q    <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            timeout_q <= timeout_d;
        end
    end
    // next state: a req drop wins over the hold limit, both lead through the turnaround
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |req ? OWN : IDLE;
            OWN:     state_d = (rel_drop || rel_to) ? TURN : OWN;
            TURN:    state_d = (turn_q <= 4'd1) ? IDLE : TURN;
            default: state_d = IDLE;
        endcase
    end
    // next values of grant, pointers, counters and the timeout pulse
    always_comb begin
        grant_d   = (state_d != OWN) ? 4'b0000 : (state_q == IDLE) ? (4'b0001 << pick) : grant_q;
        owner_d   = (state_q == IDLE) ? pick : owner_q;
        last_d    = (rel_drop || rel_to) ? owner_q : last_q;
        hold_d    = (state_d != OWN) ? 8'd0 : (state_q == IDLE) ? 8'd1 : (hold_q == 8'hff) ? hold_q : hold_q + 8'd1;
        turn_d    = (rel_drop || rel_to) ? 4'(TURN_CYCLES) : (state_q == TURN) ? turn_q - 4'd1 : 4'd0;
        timeout_d = rel_to;
    end
    assign grant   = grant_q;
    assign oen     = ~grant_q;
    assign busy    = state_q != IDLE;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_bus_driver_arbiter.sv
// tb_bus_driver_arbiter: directed table, corner sequences and random invariants for bus_driver_arbiter
module tb_bus_driver_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] g0, o0, g1, o1;
    logic       b0, t0, b1, t1;
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    bus_driver_arbiter u_def (
        .clk(clk), .reset(reset), .req(req),
        .grant(g0), .oen(o0), .busy(b0), .timeout(t0)
    );

    bus_driver_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(3)) u_to (
        .clk(clk), .reset(reset), .req(req),
        .grant(g1), .oen(o1), .busy(b1), .timeout(t1)
    );

    function automatic logic [3:0] inv4(input logic [3:0] x);
        return ~x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        #3;
        chk("rst_grant_def", g0, 4'b0000);
        chk("rst_oen_def", o0, 4'b1111);
        chk("rst_busy_def", b0, 1'b0);
        chk("rst_to_def", t0, 1'b0);
        chk("rst_grant_to", g1, 4'b0000);
        chk("rst_oen_to", o1, 4'b1111);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [3:0] prev, rq;
        int rise;
        int w [4];
        tbl[0]  = '{4'b0101, 4'b0001, 1'b1};
        tbl[1]  = '{4'b0101, 4'b0001, 1'b1};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0100, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0100, 1'b1};
        tbl[6]  = '{4'b1011, 4'b0000, 1'b1};
        tbl[7]  = '{4'b1011, 4'b0000, 1'b0};
        tbl[8]  = '{4'b1011, 4'b1000, 1'b1};
        tbl[9]  = '{4'b0011, 4'b0000, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0010, 4'b0010, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1};
        tbl[14] = '{4'b0001, 4'b0000, 1'b0};
        tbl[15] = '{4'b0001, 4'b0001, 1'b1};
        tbl[16] = '{4'b0000, 4'b0000, 1'b1};
        tbl[17] = '{4'b0000, 4'b0000, 1'b0};

        do_reset();
        for (int k = 0; k < 18; k++) begin
            req = tbl[k].req;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_grant", k), g0, tbl[k].grant);
            chk($sformatf("tbl%0d_oen", k), o0, inv4(tbl[k].grant));
            chk($sformatf("tbl%0d_busy", k), b0, tbl[k].busy);
            chk($sformatf("tbl%0d_timeout", k), t0, 1'b0);
        end

        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("rot%0d_%0d_grant", i, c), g1, (c < 3) ? (4'b0001 << (i % 4)) : 4'b0000);
                chk($sformatf("rot%0d_%0d_oen", i, c), o1, (c < 3) ? inv4(4'b0001 << (i % 4)) : 4'b1111);
                chk($sformatf("rot%0d_%0d_timeout", i, c), t1, c == 3);
                chk($sformatf("rot%0d_%0d_busy", i, c), b1, c != 5);
            end
        end
        chk("unlimited_hold_def", g0, 4'b0001);

        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("coinc_own%0d", c), g1, 4'b0100);
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
        chk("coinc_grant", g1, 4'b0000);
        chk("coinc_timeout", t1, 1'b0);
        chk("coinc_busy", b1, 1'b1);
        @(posedge clk);
        #1;
        chk("coinc_timeout_next", t1, 1'b0);

        do_reset();
        req = 4'b0001;
        @(posedge clk);
        #1;
        chk("midrst_own", g0, 4'b0001);
        #2 reset = 1'b1;
        #1;
        chk("midrst_grant", g0, 4'b0000);
        chk("midrst_oen", o0, 4'b1111);
        chk("midrst_busy", b0, 1'b0);
        req = 4'b1000;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_grant", g0, 4'b1000);
        chk("postrst_oen", o0, 4'b0111);

        do_reset();
        prev = 4'b0000;
        rise = -1;
        for (int j = 0; j < 4; j++) w[j] = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int j = 0; j < 4; j++)
                if ($urandom_range(7) == 0) req[j] = ~req[j];
            rq = req;
            @(posedge clk);
            #1;
            chk("rnd_onehot_def", $countones(g0) <= 1, 1'b1);
            chk("rnd_oen_def", o0, inv4(g0));
            chk("rnd_onehot_to", $countones(g1) <= 1, 1'b1);
            chk("rnd_oen_to", o1, inv4(g1));
            if (t1) chk("rnd_timeout_released", g1, 4'b0000);
            if (prev != 4'b0000 && g1 == 4'b0000) rise = n;
            if (prev == 4'b0000 && g1 != 4'b0000 && rise >= 0) chk("rnd_gap", (n - rise) >= 3, 1'b1);
            for (int j = 0; j < 4; j++) begin
                if (!rq[j] || g1[j]) w[j] = 0;
                else if (prev == 4'b0000 && g1 != 4'b0000) begin
                    w[j]++;
                    chk($sformatf("rnd_starve%0d", j), w[j] <= 3, 1'b1);
                end
            end
            prev = g1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
